csc_ctrl: RTL and testbench

Sequencer and configuration controller for the 3x3 colour-space-conversion datapath (`mat_mul_3x3`). It holds a double-buffered coefficient/bias bank that is written through a register port and swapped only at frame boundaries. It gates the multiplier's enable from a valid/ready pixel handshake and tracks whether the multiplier's output register holds valid data.

---
 rtl/csc_pkg.sv | 27 ++
 rtl/csc_cfg_bank.sv | 96 +++++++++
 rtl/csc_ctrl.sv | 147 ++++++++++++++
 tb/tb_csc_ctrl.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/csc_pkg.sv
// csc_pkg: shared constants and types for the colour-space-conversion controller.
// Optional feature macro used by this slice: CSC_BYPASS_EN.
package csc_pkg;

  localparam int CSC_NCOEF = 9;
  localparam int CSC_NBIAS = 3;

  localparam logic [3:0] CSC_ADDR_COEF00 = 4'd0;
  localparam logic [3:0] CSC_ADDR_COEF01 = 4'd1;
  localparam logic [3:0] CSC_ADDR_COEF02 = 4'd2;
  localparam logic [3:0] CSC_ADDR_COEF10 = 4'd3;
  localparam logic [3:0] CSC_ADDR_COEF11 = 4'd4;
  localparam logic [3:0] CSC_ADDR_COEF12 = 4'd5;
  localparam logic [3:0] CSC_ADDR_COEF20 = 4'd6;
  localparam logic [3:0] CSC_ADDR_COEF21 = 4'd7;
  localparam logic [3:0] CSC_ADDR_COEF22 = 4'd8;
  localparam logic [3:0] CSC_ADDR_BIAS0  = 4'd9;
  localparam logic [3:0] CSC_ADDR_BIAS1  = 4'd10;
  localparam logic [3:0] CSC_ADDR_BIAS2  = 4'd11;
  localparam logic [3:0] CSC_ADDR_BYPASS = 4'd12;

  typedef enum logic {
    CSC_IDLE,
    CSC_FRAME
  } csc_state_e;

endpackage

// File: rtl/csc_cfg_bank.sv
// csc_cfg_bank: shadow/active coefficient and bias registers with load strobe.
// CSC_BYPASS_EN adds a bypass flag at address 12 forcing an identity matrix.
module csc_cfg_bank
  import csc_pkg::*;
#(
  parameter int CSC_WIDTH  = 8,
  parameter int BIAS_WIDTH = 8,
  parameter int CFG_WIDTH  = 8
) (
  input  logic                            clk,
  input  logic                            rstn,
  input  logic                            cfg_we,
  input  logic [3:0]                      cfg_addr,
  input  logic [CFG_WIDTH-1:0]            cfg_wdata,
  input  logic                            load,
  output logic [CSC_NCOEF*CSC_WIDTH-1:0]  coef,
  output logic [CSC_NBIAS*BIAS_WIDTH-1:0] bias
);

  logic [CSC_WIDTH-1:0]  coef_sh  [CSC_NCOEF];
  logic [CSC_WIDTH-1:0]  coef_act [CSC_NCOEF];
  logic [BIAS_WIDTH-1:0] bias_sh  [CSC_NBIAS];
  logic [BIAS_WIDTH-1:0] bias_act [CSC_NBIAS];
  logic [CSC_NCOEF-1:0]  coef_wen;
  logic [CSC_NBIAS-1:0]  bias_wen;
  logic                  byp;

  always_comb begin
    for (int i = 0; i < CSC_NCOEF; i++)
      coef_wen[i] = cfg_we
        & (cfg_addr == CSC_ADDR_COEF00 + 4'(i));
    for (int i = 0; i < CSC_NBIAS; i++)
      bias_wen[i] = cfg_we
        & (cfg_addr == CSC_ADDR_BIAS0 + 4'(i));
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_sh <= '{default: '0};
      bias_sh <= '{default: '0};
    end else begin
      for (int i = 0; i < CSC_NCOEF; i++)
        if (coef_wen[i])
          coef_sh[i] <= cfg_wdata[CSC_WIDTH-1:0];
      for (int i = 0; i < CSC_NBIAS; i++)
        if (bias_wen[i])
          bias_sh[i] <= cfg_wdata[BIAS_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      coef_act <= '{default: '0};
      bias_act <= '{default: '0};
    end else if (load) begin
      coef_act <= coef_sh;
      bias_act <= bias_sh;
    end
  end

`ifdef CSC_BYPASS_EN
  logic byp_sh;
  logic byp_act;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      byp_sh  <= 1'b0;
      byp_act <= 1'b0;
    end else begin
      if (cfg_we && cfg_addr == CSC_ADDR_BYPASS)
        byp_sh <= cfg_wdata[0];
      if (load)
        byp_act <= byp_sh;
    end
  end

  assign byp = byp_act;
`else
  assign byp = 1'b0;
`endif

  // Bypass only masks the outputs; active values survive for un-bypass.
  always_comb begin
    for (int i = 0; i < CSC_NCOEF; i++) begin
      if (byp)
        coef[i*CSC_WIDTH +: CSC_WIDTH] =
          (i % 4 == 0) ? CSC_WIDTH'(1) : '0;
      else
        coef[i*CSC_WIDTH +: CSC_WIDTH] = coef_act[i];
    end
    for (int i = 0; i < CSC_NBIAS; i++)
      bias[i*BIAS_WIDTH +: BIAS_WIDTH] =
        byp ? '0 : bias_act[i];
  end

endmodule

// File: rtl/csc_ctrl.sv
// csc_ctrl: frame sequencer, pixel handshake and coefficient commit control.
// CSC_BYPASS_EN enables the identity-bypass flag in the config bank.
module csc_ctrl
  import csc_pkg::*;
#(
  parameter int CSC_WIDTH  = 8,
  parameter int BIAS_WIDTH = 8,
  parameter int CFG_WIDTH  = 8,
  parameter int FCNT_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  i_cfg_we,
  input  logic [3:0]            i_cfg_addr,
  input  logic [CFG_WIDTH-1:0]  i_cfg_wdata,
  input  logic                  i_cfg_commit,
  output logic                  o_cfg_pending,
  input  logic                  i_valid,
  input  logic                  i_sof,
  input  logic                  i_eof,
  output logic                  o_ready,
  output logic                  o_en,
  output logic [CSC_WIDTH-1:0]  o_coef00,
  output logic [CSC_WIDTH-1:0]  o_coef01,
  output logic [CSC_WIDTH-1:0]  o_coef02,
  output logic [CSC_WIDTH-1:0]  o_coef10,
  output logic [CSC_WIDTH-1:0]  o_coef11,
  output logic [CSC_WIDTH-1:0]  o_coef12,
  output logic [CSC_WIDTH-1:0]  o_coef20,
  output logic [CSC_WIDTH-1:0]  o_coef21,
  output logic [CSC_WIDTH-1:0]  o_coef22,
  output logic [BIAS_WIDTH-1:0] o_bias0,
  output logic [BIAS_WIDTH-1:0] o_bias1,
  output logic [BIAS_WIDTH-1:0] o_bias2,
  output logic                  o_valid,
  input  logic                  i_ready,
  output logic [FCNT_WIDTH-1:0] o_frame_cnt,
  output logic                  o_err
);

  localparam int CW = CSC_WIDTH;
  localparam int BW = BIAS_WIDTH;

  csc_state_e            state_q, state_d;
  logic                  pend_q, pend_d;
  logic                  vld_q, vld_d;
  logic                  err_q;
  logic [FCNT_WIDTH-1:0] fcnt_q;
  logic                  accept;
  logic                  load;
  logic                  err_set;
  logic [CSC_NCOEF*CW-1:0] coef;
  logic [CSC_NBIAS*BW-1:0] bias;

  assign o_ready = !vld_q | i_ready;
  assign accept  = i_valid & o_ready;
  assign o_en    = accept;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    err_set = 1'b0;
    unique case (state_q)
      CSC_IDLE: begin
        if (accept) begin
          err_set = !i_sof;
          if (i_sof & !i_eof)
            state_d = CSC_FRAME;
        end else begin
          load = i_cfg_commit | pend_q;
        end
      end
      CSC_FRAME: begin
        if (accept) begin
          err_set = i_sof;
          if (i_eof) begin
            state_d = CSC_IDLE;
            load    = i_cfg_commit | pend_q;
          end
        end
      end
      default: state_d = CSC_IDLE;
    endcase
  end

  assign pend_d = load ? 1'b0 : (pend_q | i_cfg_commit);

  always_comb begin
    unique case (1'b1)
      accept:                      vld_d = 1'b1;
      !accept & vld_q & i_ready:   vld_d = 1'b0;
      default:                     vld_d = vld_q;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= CSC_IDLE;
      pend_q  <= 1'b0;
      vld_q   <= 1'b0;
      err_q   <= 1'b0;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      vld_q   <= vld_d;
      if (err_set)
        err_q <= 1'b1;
      if (accept & i_eof)
        fcnt_q <= fcnt_q + FCNT_WIDTH'(1);
    end
  end

  csc_cfg_bank #(
    .CSC_WIDTH  (CSC_WIDTH),
    .BIAS_WIDTH (BIAS_WIDTH),
    .CFG_WIDTH  (CFG_WIDTH)
  ) u_bank (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (i_cfg_we),
    .cfg_addr  (i_cfg_addr),
    .cfg_wdata (i_cfg_wdata),
    .load      (load),
    .coef      (coef),
    .bias      (bias)
  );

  assign o_coef00 = coef[0*CW +: CW];
  assign o_coef01 = coef[1*CW +: CW];
  assign o_coef02 = coef[2*CW +: CW];
  assign o_coef10 = coef[3*CW +: CW];
  assign o_coef11 = coef[4*CW +: CW];
  assign o_coef12 = coef[5*CW +: CW];
  assign o_coef20 = coef[6*CW +: CW];
  assign o_coef21 = coef[7*CW +: CW];
  assign o_coef22 = coef[8*CW +: CW];
  assign o_bias0  = bias[0*BW +: BW];
  assign o_bias1  = bias[1*BW +: BW];
  assign o_bias2  = bias[2*BW +: BW];

  assign o_cfg_pending = pend_q;
  assign o_valid       = vld_q;
  assign o_frame_cnt   = fcnt_q;
  assign o_err         = err_q;

endmodule

// File: tb/tb_csc_ctrl.sv
// tb_csc_ctrl: directed vector table plus hand sequences for csc_ctrl.
// Bypass checks are compiled in when CSC_BYPASS_EN is defined.
module tb_csc_ctrl;

  logic       clk = 1'b0;
  logic       rstn;
  logic       cfg_we;
  logic [3:0] cfg_addr;
  logic [7:0] cfg_wdata;
  logic       cfg_commit;
  logic       cfg_pending;
  logic       vin, sof, eof, rdy_out, en, vout, rdy_in;
  logic [7:0] c00, c01, c02, c10, c11, c12, c20, c21, c22;
  logic [7:0] b0, b1, b2, fcnt;
  logic       err;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  csc_ctrl dut (
    .clk(clk), .rstn(rstn),
    .i_cfg_we(cfg_we), .i_cfg_addr(cfg_addr),
    .i_cfg_wdata(cfg_wdata), .i_cfg_commit(cfg_commit),
    .o_cfg_pending(cfg_pending),
    .i_valid(vin), .i_sof(sof), .i_eof(eof),
    .o_ready(rdy_out), .o_en(en),
    .o_coef00(c00), .o_coef01(c01), .o_coef02(c02),
    .o_coef10(c10), .o_coef11(c11), .o_coef12(c12),
    .o_coef20(c20), .o_coef21(c21), .o_coef22(c22),
    .o_bias0(b0), .o_bias1(b1), .o_bias2(b2),
    .o_valid(vout), .i_ready(rdy_in),
    .o_frame_cnt(fcnt), .o_err(err)
  );

  typedef struct {
    logic       we;
    logic [3:0] addr;
    logic [7:0] wd;
    logic       cm, v, s, e, r;
    logic [7:0] x00, x22, xb2;
    logic       xpend, xrdy, xen, xvld;
    logic [7:0] xfc;
    logic       xerr;
  } vec_t;

  vec_t tbl [17];

  function automatic vec_t mk(
    input logic we, input logic [3:0] addr,
    input logic [7:0] wd, input logic cm,
    input logic v, input logic s, input logic e,
    input logic r, input logic [7:0] x00,
    input logic [7:0] x22, input logic [7:0] xb2,
    input logic xpend, input logic xrdy,
    input logic xen, input logic xvld,
    input logic [7:0] xfc, input logic xerr);
    vec_t t;
    t.we = we; t.addr = addr; t.wd = wd; t.cm = cm;
    t.v = v; t.s = s; t.e = e; t.r = r;
    t.x00 = x00; t.x22 = x22; t.xb2 = xb2;
    t.xpend = xpend; t.xrdy = xrdy; t.xen = xen;
    t.xvld = xvld; t.xfc = xfc; t.xerr = xerr;
    return t;
  endfunction

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled 2ns later.
  task automatic drive(input logic we, input logic [3:0] a,
                       input logic [7:0] wd, input logic cm,
                       input logic v, input logic s,
                       input logic e, input logic r);
    @(negedge clk);
    cfg_we = we; cfg_addr = a; cfg_wdata = wd;
    cfg_commit = cm; vin = v; sof = s; eof = e; rdy_in = r;
    #2;
  endtask

  task automatic idle();
    drive(0, 4'd0, 8'd0, 0, 0, 0, 0, 1);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rstn = 1'b0;
    #2;
    chk("rst_pending", 32'(cfg_pending), 0);
    @(negedge clk);
    rstn = 1'b1;
  endtask

  initial begin
    rstn = 1'b0;
    cfg_we = 0; cfg_addr = 0; cfg_wdata = 0; cfg_commit = 0;
    vin = 0; sof = 0; eof = 0; rdy_in = 1;
    repeat (3) @(negedge clk);
    rstn = 1'b1;

    //        we a  wd cm v s e r  c00 c22 b2 pd rdy en vld fc er
    tbl[0]  = mk(0,0, 0, 1,0,0,0,1,  0,  0, 0, 0, 1, 0, 0, 0, 0);
    tbl[1]  = mk(0,0, 0, 0,0,0,0,1,  1,  9,12, 0, 1, 0, 0, 0, 0);
    tbl[2]  = mk(1,0, 5, 0,0,0,0,1,  1,  9,12, 0, 1, 0, 0, 0, 0);
    tbl[3]  = mk(0,0, 0, 0,1,1,0,1,  1,  9,12, 0, 1, 1, 0, 0, 0);
    tbl[4]  = mk(0,0, 0, 1,1,0,0,1,  1,  9,12, 0, 1, 1, 1, 0, 0);
    tbl[5]  = mk(0,0, 0, 0,1,0,0,1,  1,  9,12, 1, 1, 1, 1, 0, 0);
    tbl[6]  = mk(0,0, 0, 0,1,0,1,1,  1,  9,12, 1, 1, 1, 1, 0, 0);
    tbl[7]  = mk(0,0, 0, 0,0,0,0,1,  5,  9,12, 0, 1, 0, 1, 1, 0);
    tbl[8]  = mk(0,0, 0, 0,0,0,0,0,  5,  9,12, 0, 1, 0, 0, 1, 0);
    tbl[9]  = mk(0,0, 0, 0,1,1,0,1,  5,  9,12, 0, 1, 1, 0, 1, 0);
    tbl[10] = mk(0,0, 0, 0,1,0,0,0,  5,  9,12, 0, 0, 0, 1, 1, 0);
    tbl[11] = mk(0,0, 0, 0,1,0,0,0,  5,  9,12, 0, 0, 0, 1, 1, 0);
    tbl[12] = mk(0,0, 0, 0,1,0,0,1,  5,  9,12, 0, 1, 1, 1, 1, 0);
    tbl[13] = mk(0,0, 0, 0,1,1,0,1,  5,  9,12, 0, 1, 1, 1, 1, 0);
    tbl[14] = mk(0,0, 0, 0,1,0,1,1,  5,  9,12, 0, 1, 1, 1, 1, 1);
    tbl[15] = mk(0,0, 0, 0,1,1,1,1,  5,  9,12, 0, 1, 1, 1, 2, 1);
    tbl[16] = mk(0,0, 0, 0,0,0,0,1,  5,  9,12, 0, 1, 0, 1, 3, 1);

    for (int i = 0; i < 12; i++)
      drive(1, 4'(i), 8'(i + 1), 0, 0, 0, 0, 1);

    for (int i = 0; i < 17; i++) begin
      drive(tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].cm,
            tbl[i].v, tbl[i].s, tbl[i].e, tbl[i].r);
      chk($sformatf("v%0d_coef00", i), 32'(c00), 32'(tbl[i].x00));
      chk($sformatf("v%0d_coef22", i), 32'(c22), 32'(tbl[i].x22));
      chk($sformatf("v%0d_bias2", i), 32'(b2), 32'(tbl[i].xb2));
      chk($sformatf("v%0d_pend", i), 32'(cfg_pending),
          32'(tbl[i].xpend));
      chk($sformatf("v%0d_ready", i), 32'(rdy_out), 32'(tbl[i].xrdy));
      chk($sformatf("v%0d_en", i), 32'(en), 32'(tbl[i].xen));
      chk($sformatf("v%0d_valid", i), 32'(vout), 32'(tbl[i].xvld));
      chk($sformatf("v%0d_fcnt", i), 32'(fcnt), 32'(tbl[i].xfc));
      chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].xerr));
    end

    chk("coef01", 32'(c01), 2);
    chk("coef02", 32'(c02), 3);
    chk("coef10", 32'(c10), 4);
    chk("coef11", 32'(c11), 5);
    chk("coef12", 32'(c12), 6);
    chk("coef20", 32'(c20), 7);
    chk("coef21", 32'(c21), 8);
    chk("bias0", 32'(b0), 10);
    chk("bias1", 32'(b1), 11);

    // Addresses 13..15 hit nothing.
    drive(1, 4'd13, 8'h77, 0, 0, 0, 0, 1);
    drive(1, 4'd15, 8'h66, 0, 0, 0, 0, 1);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    idle();
    chk("a13_coef00", 32'(c00), 5);
    chk("a13_bias2", 32'(b2), 12);

`ifdef CSC_BYPASS_EN
    drive(1, 4'd12, 8'd1, 0, 0, 0, 0, 1);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    idle();
    chk("byp_coef00", 32'(c00), 1);
    chk("byp_coef01", 32'(c01), 0);
    chk("byp_coef11", 32'(c11), 1);
    chk("byp_coef21", 32'(c21), 0);
    chk("byp_coef22", 32'(c22), 1);
    chk("byp_bias0", 32'(b0), 0);
    chk("byp_bias2", 32'(b2), 0);
    drive(1, 4'd12, 8'd0, 0, 0, 0, 0, 1);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    idle();
    chk("unbyp_coef00", 32'(c00), 5);
    chk("unbyp_coef01", 32'(c01), 2);
    chk("unbyp_bias2", 32'(b2), 12);
`else
    drive(1, 4'd12, 8'd1, 0, 0, 0, 0, 1);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    idle();
    chk("nobyp_coef00", 32'(c00), 5);
    chk("nobyp_coef01", 32'(c01), 2);
    chk("nobyp_bias2", 32'(b2), 12);
`endif

    // sof inside a frame: error, still FRAME so a commit waits.
    do_reset();
    drive(0, 4'd0, 8'd0, 0, 1, 1, 0, 1);
    drive(0, 4'd0, 8'd0, 0, 1, 1, 0, 1);
    chk("sof2_err_pre", 32'(err), 0);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    chk("sof2_err", 32'(err), 1);
    idle();
    chk("sof2_frame_pend", 32'(cfg_pending), 1);
    drive(0, 4'd0, 8'd0, 0, 1, 0, 1, 1);
    chk("sof2_eof_pend", 32'(cfg_pending), 1);
    idle();
    chk("sof2_apply", 32'(cfg_pending), 0);
    chk("sof2_fcnt", 32'(fcnt), 1);

    // Reset mid-frame drops the pending commit and the frame.
    drive(0, 4'd0, 8'd0, 0, 1, 1, 0, 1);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    idle();
    chk("mid_pend", 32'(cfg_pending), 1);
    do_reset();
    idle();
    chk("mid_rst_pend", 32'(cfg_pending), 0);
    chk("mid_rst_fcnt", 32'(fcnt), 0);
    chk("mid_rst_err", 32'(err), 0);
    chk("mid_rst_valid", 32'(vout), 0);
    drive(0, 4'd0, 8'd0, 1, 0, 0, 0, 1);
    idle();
    chk("mid_rst_idle", 32'(cfg_pending), 0);

    // eof in IDLE without sof.
    do_reset();
    drive(0, 4'd0, 8'd0, 0, 1, 0, 1, 1);
    idle();
    chk("eof_idle_err", 32'(err), 1);
    chk("eof_idle_fcnt", 32'(fcnt), 1);

    // Single-beat frame.
    do_reset();
    drive(0, 4'd0, 8'd0, 0, 1, 1, 1, 1);
    idle();
    chk("single_fcnt", 32'(fcnt), 1);
    chk("single_err", 32'(err), 0);

    // Counter wrap after 256 frames.
    do_reset();
    for (int i = 0; i < 256; i++) begin
      drive(0, 4'd0, 8'd0, 0, 1, 1, 1, 1);
      if (i == 255)
        chk("wrap_255", 32'(fcnt), 255);
    end
    idle();
    chk("wrap_fcnt", 32'(fcnt), 0);
    chk("wrap_err", 32'(err), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
